// File: rtl/traffic_phase_arbiter.sv
// Purpose: arbitrates the non-main phase among side road, two ped buttons and emergency preempt.
// Latency: grant_valid rises 2 cycles after the IDLE cycle that qualifies a request (IDLE->ARB->ISSUE).
// Backpressure: grant_valid is held with grant_id stable until phase_ack; requests keep latching meanwhile.
module traffic_phase_arbiter #(
  parameter int unsigned MIN_GREEN = 100,
  parameter logic [7:0]  PED_EXT   = 8'd50,
  parameter int unsigned TIMEOUT   = 1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_side,
  input  logic       req_ped_main,
  input  logic       req_ped_side,
  input  logic       emerg,
  input  logic       phase_ack,
  input  logic       phase_done,
  output logic       grant_valid,
  output logic [1:0] grant_id,
  output logic [2:0] pending,
  output logic [7:0] timer_adj,
  output logic       busy,
  output logic       fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    ISSUE = 2'd2,
    SERVE = 2'd3
  } state_t;

  localparam int MGW = $clog2(MIN_GREEN + 1);

  state_t         state, state_nxt;
  logic [MGW-1:0] mg_cnt;
  logic           mg_done;
  logic [15:0]    wd_cnt;
  logic           wd_expire;
  logic [1:0]     rr_ptr;
  logic           arb_found;
  logic [1:0]     arb_id;
  logic [2:0]     pend_clr;
  logic           fault_set;
  logic [3:0]     pend4;

  assign mg_done   = (mg_cnt == MGW'(MIN_GREEN));
  assign wd_expire = (wd_cnt == 16'(TIMEOUT - 1));
  // Padding bit keeps the rotated index in range for every 2-bit value.
  assign pend4     = {1'b0, pending};

  // Pick the winner: emergency first, otherwise first pending bit at/after rr_ptr (wrapping 2->0).
  always_comb begin
    logic [1:0] idx;
    arb_found = 1'b0;
    arb_id    = 2'd0;
    idx       = 2'd0;
    if (emerg) begin
      arb_found = 1'b1;
      arb_id    = 2'd3;
    end else if (mg_done) begin
      for (int k = 0; k < 3; k++) begin
        idx = 2'((int'(rr_ptr) + k) % 3);
        if (!arb_found && pend4[idx]) begin
          arb_found = 1'b1;
          arb_id    = idx;
        end
      end
    end
  end

  // Next-state and Moore outputs; ack/timeout also produce the pending-clear mask.
  always_comb begin
    state_nxt   = state;
    grant_valid = 1'b0;
    busy        = 1'b1;
    timer_adj   = 8'd0;
    pend_clr    = 3'b000;
    fault_set   = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (emerg || (mg_done && (|pending))) state_nxt = ARB;
      end
      ARB: begin
        // Emergency may have dropped since IDLE; fall back without disturbing mg_cnt.
        state_nxt = arb_found ? ISSUE : IDLE;
      end
      ISSUE: begin
        grant_valid = 1'b1;
        if (phase_ack) begin
          state_nxt = SERVE;
          pend_clr  = (grant_id == 2'd3) ? 3'b000 : (3'b001 << grant_id);
        end
      end
      SERVE: begin
        timer_adj = ((grant_id == 2'd1) || (grant_id == 2'd2)) ? PED_EXT : 8'd0;
        if (phase_done) begin
          state_nxt = IDLE;
        end else if (wd_expire) begin
          // Stuck phase: flag it and drop the request so it does not re-grant forever.
          state_nxt = IDLE;
          fault_set = 1'b1;
          pend_clr  = (grant_id == 2'd3) ? 3'b000 : (3'b001 << grant_id);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Request latches: a new request in the clearing cycle wins over the clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pending <= 3'b000;
    else          pending <= (pending & ~pend_clr) | {req_ped_side, req_ped_main, req_side};
  end

  // Main-green hold counter: restarts when a served phase returns to IDLE, saturates at MIN_GREEN.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                  mg_cnt <= '0;
    else if (state == SERVE && state_nxt == IDLE)  mg_cnt <= '0;
    else if (state == IDLE && !mg_done)            mg_cnt <= mg_cnt + 1'b1;
  end

  // Grant id and round-robin pointer are captured in ARB; emergency does not move the pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_id <= 2'd0;
      rr_ptr   <= 2'd0;
    end else if (state == ARB && arb_found) begin
      grant_id <= arb_id;
      if (arb_id != 2'd3) rr_ptr <= (arb_id == 2'd2) ? 2'd0 : arb_id + 2'd1;
    end
  end

  // Watchdog counts cycles spent in SERVE; zero everywhere else.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            wd_cnt <= 16'd0;
    else if (state == SERVE) wd_cnt <= wd_cnt + 16'd1;
    else                     wd_cnt <= 16'd0;
  end

  // Sticky fault flag; only reset clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       fault <= 1'b0;
    else if (fault_set) fault <= 1'b1;
  end

endmodule

// File: tb/tb_traffic_phase_arbiter.sv
// Bench for traffic_phase_arbiter: expected grant ids are queued when stimulus is applied
// and popped when grant_valid is observed; each scenario task checks its own outputs.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_traffic_phase_arbiter;
  localparam int         MIN_GREEN = 100;
  localparam int         TIMEOUT   = 1000;
  localparam logic [7:0] PED_EXT   = 8'd50;

  logic       clk;
  logic       reset_n;
  logic       req_side, req_ped_main, req_ped_side, emerg, phase_ack, phase_done;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic [2:0] pending;
  logic [7:0] timer_adj;
  logic       busy;
  logic       fault;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int exp_q[$];

  traffic_phase_arbiter #(
    .MIN_GREEN(MIN_GREEN),
    .PED_EXT  (PED_EXT),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_side    (req_side),
    .req_ped_main(req_ped_main),
    .req_ped_side(req_ped_side),
    .emerg       (emerg),
    .phase_ack   (phase_ack),
    .phase_done  (phase_done),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .pending     (pending),
    .timer_adj   (timer_adj),
    .busy        (busy),
    .fault       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_inputs;
    req_side     = 1'b0;
    req_ped_main = 1'b0;
    req_ped_side = 1'b0;
    emerg        = 1'b0;
    phase_ack    = 1'b0;
    phase_done   = 1'b0;
  endtask

  task automatic do_reset;
    clear_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    cyc     = 0;
    exp_q.delete();
  endtask

  // Waits (bounded) for grant_valid; reports whether it appeared.
  task automatic wait_grant(input int budget, output bit got);
    int n;
    n = 0;
    while (grant_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    got = (grant_valid === 1'b1);
  endtask

  task automatic test_reset;
    logic [16:0] outs;
    reset_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      {req_side, req_ped_main, req_ped_side, emerg, phase_ack, phase_done} = 6'($urandom);
      tick();
      outs = {grant_valid, grant_id, pending, timer_adj, busy, fault};
      checks++;
      if (outs !== 17'd0) begin
        failures++;
        $display("FAIL reset_outputs iter=%0d got=%h want=0", i, outs);
      end
    end
    clear_inputs();
    reset_n = 1'b1;
    cyc = 0;
    repeat (300) tick();
    checks++;
    if (busy !== 1'b0 || grant_valid !== 1'b0 || pending !== 3'b000) begin
      failures++;
      $display("FAIL reset_idle busy=%b grant_valid=%b pending=%b want 0/0/000", busy, grant_valid, pending);
    end
  endtask

  task automatic test_min_green;
    bit got;
    int e;
    do_reset();
    repeat (10) tick();
    req_side = 1'b1;
    exp_q.push_back(0);
    tick();
    req_side = 1'b0;
    checks++;
    if (pending !== 3'b001) begin
      failures++;
      $display("FAIL mg_pending_latch got=%b want=001", pending);
    end
    wait_grant(300, got);
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL mg_grant_timeout grant_valid=%b want=1", grant_valid);
    end
    e = exp_q.pop_front();
    checks++;
    if (grant_id !== 2'(e)) begin
      failures++;
      $display("FAIL mg_grant_id got=%0d want=%0d", grant_id, e);
    end
    checks++;
    if (cyc !== MIN_GREEN + 2) begin
      failures++;
      $display("FAIL mg_latency got_cycle=%0d want=%0d", cyc, MIN_GREEN + 2);
    end
    phase_ack = 1'b1;
    tick();
    phase_ack = 1'b0;
    checks++;
    if (pending !== 3'b000 || grant_valid !== 1'b0 || busy !== 1'b1 || timer_adj !== 8'd0) begin
      failures++;
      $display("FAIL mg_after_ack pending=%b gv=%b busy=%b adj=%0d want 000/0/1/0",
               pending, grant_valid, busy, timer_adj);
    end
    phase_done = 1'b1;
    tick();
    phase_done = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL mg_done_idle busy=%b want=0", busy);
    end
  endtask

  task automatic test_round_robin;
    bit got;
    int e;
    logic [7:0] want_adj;
    do_reset();
    req_side = 1'b1;
    req_ped_main = 1'b1;
    req_ped_side = 1'b1;
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(0);
    for (int p = 0; p < 4; p++) begin
      wait_grant(300, got);
      checks++;
      if (!got) begin
        failures++;
        $display("FAIL rr_grant_timeout phase=%0d", p);
      end
      e = exp_q.pop_front();
      checks++;
      if (grant_id !== 2'(e)) begin
        failures++;
        $display("FAIL rr_grant_id phase=%0d got=%0d want=%0d", p, grant_id, e);
      end
      phase_ack = 1'b1;
      tick();
      phase_ack = 1'b0;
      want_adj = (e == 1 || e == 2) ? PED_EXT : 8'd0;
      checks++;
      if (timer_adj !== want_adj) begin
        failures++;
        $display("FAIL rr_timer_adj phase=%0d got=%0d want=%0d", p, timer_adj, want_adj);
      end
      phase_done = 1'b1;
      tick();
      phase_done = 1'b0;
      checks++;
      if (timer_adj !== 8'd0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL rr_after_done phase=%0d adj=%0d busy=%b want 0/0", p, timer_adj, busy);
      end
    end
    clear_inputs();
  endtask

  task automatic test_emergency;
    bit got;
    int e, start;
    do_reset();
    repeat (5) tick();
    emerg = 1'b1;
    exp_q.push_back(3);
    start = cyc;
    wait_grant(20, got);
    e = exp_q.pop_front();
    checks++;
    if (!got || grant_id !== 2'(e)) begin
      failures++;
      $display("FAIL emerg_grant got_valid=%b id=%0d want 1/%0d", got, grant_id, e);
    end
    checks++;
    if (cyc - start !== 2) begin
      failures++;
      $display("FAIL emerg_latency got=%0d want=2", cyc - start);
    end
    phase_ack = 1'b1;
    tick();
    phase_ack = 1'b0;
    emerg = 1'b0;
    phase_done = 1'b1;
    tick();
    phase_done = 1'b0;
    req_side = 1'b1;
    exp_q.push_back(0);
    tick();
    req_side = 1'b0;
    wait_grant(300, got);
    e = exp_q.pop_front();
    checks++;
    if (!got || grant_id !== 2'(e)) begin
      failures++;
      $display("FAIL emerg_side_grant got_valid=%b id=%0d want 1/%0d", got, grant_id, e);
    end
    emerg = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (grant_valid !== 1'b1 || grant_id !== 2'd0) begin
        failures++;
        $display("FAIL emerg_no_preempt cyc=%0d gv=%b id=%0d want 1/0", i, grant_valid, grant_id);
      end
    end
    phase_ack = 1'b1;
    tick();
    phase_ack = 1'b0;
    exp_q.push_back(3);
    phase_done = 1'b1;
    tick();
    phase_done = 1'b0;
    start = cyc;
    wait_grant(20, got);
    e = exp_q.pop_front();
    checks++;
    if (!got || grant_id !== 2'(e) || cyc - start !== 2) begin
      failures++;
      $display("FAIL emerg_regrant gv=%b id=%0d lat=%0d want 1/%0d/2", got, grant_id, cyc - start, e);
    end
    phase_ack = 1'b1;
    tick();
    phase_ack = 1'b0;
    emerg = 1'b0;
    phase_done = 1'b1;
    tick();
    clear_inputs();
  endtask

  task automatic test_watchdog;
    bit got;
    int e;
    do_reset();
    req_side = 1'b1;
    exp_q.push_back(0);
    tick();
    req_side = 1'b0;
    wait_grant(300, got);
    e = exp_q.pop_front();
    checks++;
    if (!got || grant_id !== 2'(e)) begin
      failures++;
      $display("FAIL wd_grant gv=%b id=%0d want 1/%0d", got, grant_id, e);
    end
    phase_ack = 1'b1;
    tick();
    phase_ack = 1'b0;
    req_side = 1'b1;
    tick();
    req_side = 1'b0;
    checks++;
    if (pending !== 3'b001) begin
      failures++;
      $display("FAIL wd_relatch pending=%b want=001", pending);
    end
    repeat (TIMEOUT - 2) tick();
    checks++;
    if (fault !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL wd_before_expiry fault=%b busy=%b want 0/1", fault, busy);
    end
    tick();
    checks++;
    if (fault !== 1'b1 || busy !== 1'b0 || pending !== 3'b000) begin
      failures++;
      $display("FAIL wd_expiry fault=%b busy=%b pending=%b want 1/0/000", fault, busy, pending);
    end
    repeat (20) tick();
    checks++;
    if (fault !== 1'b1) begin
      failures++;
      $display("FAIL wd_sticky fault=%b want=1", fault);
    end
  endtask

  task automatic test_corner;
    bit got;
    int e;
    do_reset();
    req_ped_main = 1'b1;
    exp_q.push_back(1);
    tick();
    req_ped_main = 1'b0;
    wait_grant(300, got);
    e = exp_q.pop_front();
    checks++;
    if (!got || grant_id !== 2'(e)) begin
      failures++;
      $display("FAIL corner_grant gv=%b id=%0d want 1/%0d", got, grant_id, e);
    end
    phase_ack = 1'b1;
    req_ped_main = 1'b1;
    tick();
    phase_ack = 1'b0;
    req_ped_main = 1'b0;
    checks++;
    if (pending !== 3'b010 || timer_adj !== PED_EXT) begin
      failures++;
      $display("FAIL corner_set_wins pending=%b adj=%0d want 010/%0d", pending, timer_adj, PED_EXT);
    end
    phase_done = 1'b1;
    tick();
    phase_done = 1'b0;
    phase_ack = 1'b1;
    phase_done = 1'b1;
    repeat (5) tick();
    phase_ack = 1'b0;
    phase_done = 1'b0;
    checks++;
    if (busy !== 1'b0 || grant_valid !== 1'b0 || pending !== 3'b010 || fault !== 1'b0) begin
      failures++;
      $display("FAIL corner_stray_ack busy=%b gv=%b pending=%b fault=%b want 0/0/010/0",
               busy, grant_valid, pending, fault);
    end
    exp_q.push_back(1);
    wait_grant(300, got);
    e = exp_q.pop_front();
    checks++;
    if (!got || grant_id !== 2'(e)) begin
      failures++;
      $display("FAIL corner_wrap_grant gv=%b id=%0d want 1/%0d", got, grant_id, e);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (grant_valid !== 1'b0 || busy !== 1'b0 || timer_adj !== 8'd0) begin
      failures++;
      $display("FAIL corner_async_reset gv=%b busy=%b adj=%0d want 0/0/0", grant_valid, busy, timer_adj);
    end
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    clear_inputs();
    reset_n = 1'b0;
    test_reset();
    test_min_green();
    test_round_robin();
    test_emergency();
    test_watchdog();
    test_corner();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout sim_time=%0t limit=500000", $time);
    $fatal(1, "simulation time limit exceeded");
  end

endmodule
